rf_access_ctrl: RTL and testbench
=================================

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock; also clocks the attached BR register file.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  requester has a valid access request.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_rs, req_rt, req_rd  input  5 each  read address A, read address B, write address.
REQ-007 req_we  input  1  request includes a write.
REQ-008 req_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  operand response is valid.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_a, rsp_b  output  32 each  operands read for rs and rt.
REQ-012 rf_adrsReadA, rf_adrsReadB, rf_adrsWrite  output  5 each  register-file address ports.
REQ-013 rf_RegEn  output  1  register-file write enable.
REQ-014 rf_write  output  32  register-file write data.
REQ-015 rf_readA, rf_readB  input  32 each  asynchronous read data from the register file.
REQ-016 wr_count  output  16  number of register-file writes performed, saturating.

Function
REQ-017 SHALL implement the FSM states IDLE, READ, WRITE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready at a rising edge.
REQ-019 Accept SHALL latch rs, rt, rd, we and wdata, then move IDLE->READ.
REQ-020 READ SHALL drive the latched rs/rt on rf_adrsReadA/B and capture rf_readA/B into rsp_a/b at the end of the cycle.
REQ-021 READ SHALL go to WRITE if we=1, else to RESP.
REQ-022 WRITE SHALL hold rf_RegEn=1 for exactly one cycle, with rf_adrsWrite=rd and rf_write=wdata, then go to RESP.
REQ-023 Operands SHALL reflect register contents before that request's own write (read-before-write).
REQ-024 RESP SHALL hold rsp_valid=1 with stable rsp_a/b until rsp_ready=1, then go to IDLE.
REQ-025 Latency from accept to rsp_valid SHALL be 3 cycles with we=1 and 2 cycles with we=0.
REQ-026 At most one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored.
REQ-027 rf_RegEn SHALL be 0 in every state other than WRITE.
REQ-028 Address outputs SHALL hold their latched values between requests.
REQ-029 wr_count SHALL increment by 1 on each cycle in which rf_RegEn=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-030 rsp_ready asserted in the same cycle rsp_valid first rises SHALL complete the response in that cycle.

Reset
REQ-031 While rst_n=0 the block SHALL force state=IDLE immediately, independent of clk.
REQ-032 While rst_n=0 the block SHALL hold req_ready=0, rsp_valid=0, rf_RegEn=0, rsp_a=rsp_b=0, all rf address and data outputs=0, and wr_count=0.
REQ-033 req_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-034 Reset during WRITE SHALL drop rf_RegEn asynchronously and perform no write at the following edge.
REQ-035 After a reset, any aborted request SHALL be lost with no response.

Configuration
REQ-036 The macro RF_ZERO_GUARD_EN SHALL select zero-register protection.
REQ-037 With RF_ZERO_GUARD_EN defined, a write with rd=0 SHALL still pass through WRITE but keep rf_RegEn=0 and leave wr_count unchanged.
REQ-038 With RF_ZERO_GUARD_EN defined, rsp_a/rsp_b SHALL be 0 for rs/rt=0 regardless of rf_readA/B.
REQ-039 With RF_ZERO_GUARD_EN undefined, address 0 SHALL be treated like every other address.

Verification (bench attaches BR preloaded with $5=20, $6=12, $7=55, $9=100)
REQ-040 Read-only test: rs=5, rt=6, we=0 -> rsp_valid 2 cycles after accept, rsp_a=20, rsp_b=12, rf_RegEn never 1.
REQ-041 Read-before-write test: rs=7, rt=9, rd=7, we=1, wdata=500 -> rsp_a=55, rsp_b=100, one RegEn pulse, wr_count=1; a follow-up read of rs=7 returns 500.
REQ-042 Backpressure test: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_a/b stable, req_ready=0 throughout, and a req_valid pulse is ignored.
REQ-043 Zero-guard test: rd=0, we=1, wdata=7, rs=0 -> with the macro, RegEn stays 0, rsp_a=0 and wr_count is unchanged; without the macro, RegEn pulses and wr_count increments.
REQ-044 Reset test: assert rst_n=0 mid-WRITE -> RegEn drops at once, the target register is unchanged, and after release req_ready=1 on the first edge.
REQ-045 Saturation test: force wr_count to 16'hFFFE, then issue 3 writes -> wr_count ends at 16'hFFFF.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// Sequencer between a requester and the BR register file: read, optional write, response.
// Define RF_ZERO_GUARD_EN to make register 0 read as zero and ignore writes to it.
module rf_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_a,
  output logic [31:0] rsp_b,
  output logic [4:0]  rf_adrsReadA,
  output logic [4:0]  rf_adrsReadB,
  output logic [4:0]  rf_adrsWrite,
  output logic        rf_RegEn,
  output logic [31:0] rf_write,
  input  logic [31:0] rf_readA,
  input  logic [31:0] rf_readB,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

`ifdef RF_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  state_t state;
  logic   we_q;
  logic   wr_en;
  logic   zero_a;
  logic   zero_b;

  assign wr_en  = we_q && !(ZG && rf_adrsWrite == 5'd0);
  assign zero_a = ZG && rf_adrsReadA == 5'd0;
  assign zero_b = ZG && rf_adrsReadB == 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_a        <= '0;
      rsp_b        <= '0;
      rf_adrsReadA <= '0;
      rf_adrsReadB <= '0;
      rf_adrsWrite <= '0;
      rf_RegEn     <= 1'b0;
      rf_write     <= '0;
      we_q         <= 1'b0;
      wr_count     <= '0;
    end else begin
      if (rf_RegEn && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            rf_adrsReadA <= req_rs;
            rf_adrsReadB <= req_rt;
            rf_adrsWrite <= req_rd;
            rf_write     <= req_wdata;
            we_q         <= req_we;
            req_ready    <= 1'b0;
            state        <= READ;
          end
        end
        READ: begin
          // Capture happens before any write, so operands are pre-write values.
          rsp_a <= zero_a ? 32'd0 : rf_readA;
          rsp_b <= zero_b ? 32'd0 : rf_readB;
          if (we_q) begin
            rf_RegEn <= wr_en;
            state    <= WRITE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          rf_RegEn  <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a BR register-file model and an operand scoreboard.
// Expectations follow RF_ZERO_GUARD_EN when it is defined for the build.
module tb_rf_access_ctrl;

`ifdef RF_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_a;
  logic [31:0] rsp_b;
  logic [4:0]  rf_adrsReadA;
  logic [4:0]  rf_adrsReadB;
  logic [4:0]  rf_adrsWrite;
  logic        rf_RegEn;
  logic [31:0] rf_write;
  logic [31:0] rf_readA;
  logic [31:0] rf_readB;
  logic [15:0] wr_count;

  logic [31:0] regs [32];
  logic        br_init;
  logic [31:0] sb_a [$];
  logic [31:0] sb_b [$];
  int          errs;
  int          checks;
  logic [15:0] exp_wr;

  rf_access_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs(req_rs),
    .req_rt(req_rt),
    .req_rd(req_rd),
    .req_we(req_we),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_a(rsp_a),
    .rsp_b(rsp_b),
    .rf_adrsReadA(rf_adrsReadA),
    .rf_adrsReadB(rf_adrsReadB),
    .rf_adrsWrite(rf_adrsWrite),
    .rf_RegEn(rf_RegEn),
    .rf_write(rf_write),
    .rf_readA(rf_readA),
    .rf_readB(rf_readB),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BR model: asynchronous read, write on rising edge.
  assign rf_readA = regs[rf_adrsReadA];
  assign rf_readB = regs[rf_adrsReadB];

  always @(posedge clk) begin
    if (!br_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[5] <= 32'd20;
      regs[6] <= 32'd12;
      regs[7] <= 32'd55;
      regs[9] <= 32'd100;
    end else if (rf_RegEn) begin
      regs[rf_adrsWrite] <= rf_write;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic xact(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic we,
                      input logic [31:0] wd, input logic [31:0] ea,
                      input logic [31:0] eb, input int hold);
    int          edges;
    int          pulses;
    int          ep;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] a0;
    logic [31:0] b0;
    ep = (we && !(ZG && rd == 5'd0)) ? 1 : 0;
    chk("req_ready_idle", req_ready, 1);
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_we    = we;
    req_wdata = wd;
    req_valid = 1'b1;
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(negedge clk);
    req_valid = 1'b0;
    edges  = 1;
    pulses = rf_RegEn ? 1 : 0;
    while (!rsp_valid && edges < 10) begin
      @(negedge clk);
      edges++;
      if (rf_RegEn) pulses++;
    end
    chk("latency", edges, we ? 3 : 2);
    chk("regen_pulses", pulses, ep);
    qa = sb_a.pop_front();
    qb = sb_b.pop_front();
    chk("rsp_a", rsp_a, qa);
    chk("rsp_b", rsp_b, qb);
    a0 = rsp_a;
    b0 = rsp_b;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_rs    = 5'd7;
        req_we    = 1'b1;
        req_valid = 1'b1;
      end
      if (i == 2) req_valid = 1'b0;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_a", rsp_a, a0);
      chk("bp_b", rsp_b, b0);
      chk("bp_ready", req_ready, 0);
      chk("bp_regen", rf_RegEn, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    if (ep == 1 && exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
    chk("wr_count", wr_count, exp_wr);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    exp_wr    = '0;
    br_init   = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rs    = '0;
    req_rt    = '0;
    req_rd    = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    @(negedge clk);
    br_init = 1'b1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_regen", rf_RegEn, 0);
    chk("rst_rsp_a", rsp_a, 0);
    chk("rst_adrs", {rf_adrsReadA, rf_adrsReadB, rf_adrsWrite}, 0);
    chk("rst_write", rf_write, 0);
    chk("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready_pre", req_ready, 0);
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);

    xact(5'd5, 5'd6, 5'd3, 1'b0, 32'd0, 32'd20, 32'd12, 0);
    chk("hold_adrsA", rf_adrsReadA, 5);
    chk("hold_adrsB", rf_adrsReadB, 6);

    xact(5'd7, 5'd9, 5'd7, 1'b1, 32'd500, 32'd55, 32'd100, 0);
    chk("rbw_count", wr_count, 1);
    xact(5'd7, 5'd9, 5'd1, 1'b0, 32'd0, 32'd500, 32'd100, 0);

    rsp_ready = 1'b0;
    xact(5'd9, 5'd5, 5'd2, 1'b0, 32'd0, 32'd100, 32'd20, 5);
    repeat (3) begin
      @(negedge clk);
      chk("ignored_req", rsp_valid, 0);
    end
    chk("r7_intact", regs[7], 500);

    xact(5'd0, 5'd5, 5'd0, 1'b1, 32'd7, 32'd0, 32'd20, 0);
    xact(5'd0, 5'd5, 5'd1, 1'b0, 32'd0, ZG ? 32'd0 : 32'd7, 32'd20, 0);

    req_rs    = 5'd5;
    req_rt    = 5'd6;
    req_rd    = 5'd9;
    req_we    = 1'b1;
    req_wdata = 32'd999;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_write_regen", rf_RegEn, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_regen", rf_RegEn, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_wr_count", wr_count, 0);
    chk("arst_adrsW", rf_adrsWrite, 0);
    exp_wr = '0;
    @(posedge clk);
    #1;
    chk("arst_no_write", regs[9], 100);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arel_pre", req_ready, 0);
    @(negedge clk);
    chk("arel_req_ready", req_ready, 1);
    chk("arel_no_rsp", rsp_valid, 0);
    xact(5'd9, 5'd7, 5'd1, 1'b0, 32'd0, 32'd100, 32'd500, 0);

    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    #1;
    chk("sat_preset", wr_count, 16'hFFFE);
    exp_wr = 16'hFFFE;
    @(negedge clk);
    xact(5'd10, 5'd10, 5'd10, 1'b1, 32'd1, 32'd0, 32'd0, 0);
    xact(5'd10, 5'd10, 5'd10, 1'b1, 32'd2, 32'd1, 32'd1, 0);
    xact(5'd10, 5'd10, 5'd10, 1'b1, 32'd3, 32'd2, 32'd2, 0);
    chk("sat_final", wr_count, 16'hFFFF);
    xact(5'd10, 5'd6, 5'd1, 1'b0, 32'd0, 32'd3, 32'd12, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
